// File: rtl/roce_icrc_pkg.sv
// Shared constants, bus payload type and CRC helpers for the RoCEv2 ICRC append stage.
package roce_icrc_pkg;

    localparam int unsigned AXIS_DATA_W   = 512;
    localparam int unsigned AXIS_KEEP_W   = AXIS_DATA_W / 8;
    localparam int unsigned ICRC_BYTES    = 4;
    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned LRH_DUMMY_LEN = 8;

    localparam int unsigned MASK_IP_TOS      = 15;
    localparam int unsigned MASK_IP_TTL      = 22;
    localparam int unsigned MASK_IP_CSUM_HI  = 24;
    localparam int unsigned MASK_IP_CSUM_LO  = 25;
    localparam int unsigned MASK_UDP_CSUM_HI = 40;
    localparam int unsigned MASK_UDP_CSUM_LO = 41;
    localparam int unsigned MASK_BTH_RESV8A  = 46;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    // LSB-first CRC-32 step over one byte
    function automatic logic [31:0] crc_update_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int unsigned k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic is_masked_byte(input int unsigned idx);
        return idx inside {MASK_IP_TOS, MASK_IP_TTL, MASK_IP_CSUM_HI, MASK_IP_CSUM_LO,
                           MASK_UDP_CSUM_HI, MASK_UDP_CSUM_LO, MASK_BTH_RESV8A};
    endfunction

    // CRC state after the all-ones dummy LRH that precedes the IP header
    function automatic logic [31:0] crc_lrh_seed();
        logic [31:0] c;
        c = CRC_INIT;
        for (int unsigned i = 0; i < LRH_DUMMY_LEN; i++) begin
            c = crc_update_byte(c, 8'hFF);
        end
        return c;
    endfunction

    localparam logic [31:0] CRC_LRH_SEED = crc_lrh_seed();

endpackage

// File: rtl/roce_icrc_append_if.sv
// AXI4-Stream bundle used on both sides of the ICRC append stage.
interface roce_icrc_append_if;
    import roce_icrc_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/roce_icrc_calc.sv
// Per-frame ICRC accumulator: masks invariant fields, skips the Ethernet header,
// folds in every kept byte of an accepted beat and restarts after the last beat.
module roce_icrc_calc
    import roce_icrc_pkg::*;
(
    input  logic                   core_clk,
    input  logic                   core_aresetn,
    input  logic                   beat_en,
    input  logic                   beat_last,
    input  logic [AXIS_DATA_W-1:0] beat_data,
    input  logic [AXIS_KEEP_W-1:0] beat_keep,
    output logic [31:0]            crc_c
);

    logic [31:0] crc_q;
    logic [31:0] crc_run;
    logic [7:0]  byte_val;
    logic        sof_q;

    // Running CRC including the beat currently on the input
    always_comb begin
        crc_run  = sof_q ? CRC_LRH_SEED : crc_q;
        byte_val = '0;
        for (int unsigned i = 0; i < AXIS_KEEP_W; i++) begin
            byte_val = beat_data[8*i +: 8];
            if (sof_q && is_masked_byte(i)) begin
                byte_val = 8'hFF;
            end
            if (beat_keep[i] && !(sof_q && (i < ETH_HDR_LEN))) begin
                crc_run = crc_update_byte(crc_run, byte_val);
            end
        end
    end

    assign crc_c = crc_run ^ CRC_XOROUT;

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            crc_q <= CRC_INIT;
            sof_q <= 1'b1;
        end else if (beat_en) begin
            if (beat_last) begin
                crc_q <= CRC_INIT;
                sof_q <= 1'b1;
            end else begin
                crc_q <= crc_run;
                sof_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/roce_icrc_append.sv
// Inline AXI4-Stream stage appending the RoCEv2 ICRC to each frame, with one
// registered output beat and an extra spill beat when the ICRC overflows the last beat.
module roce_icrc_append
    import roce_icrc_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH = 512
) (
    input  logic                       core_clk,
    input  logic                       core_aresetn,
    roce_icrc_append_if.slave          s_axis,
    roce_icrc_append_if.master         m_axis
);

    localparam int unsigned LANES    = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned SPILL_AT = LANES - ICRC_BYTES;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPILL = 2'd2
    } state_t;

    state_t     state_q, state_d;
    axis_beat_t out_q, out_d;
    axis_beat_t spill_q, spill_d;
    logic       out_valid_q, out_valid_d;

    logic       out_free_c;
    logic       s_ready_c;
    logic       accept_c;
    logic       spill_c;
    logic [6:0] nbytes_c;
    logic [6:0] lane_ofs;
    logic [6:0] spill_ofs;
    logic [31:0] crc_c;
    logic [ICRC_BYTES-1:0][7:0] icrc_bytes;
    axis_beat_t tail_beat_c;
    axis_beat_t spill_beat_c;

    assign out_free_c = !out_valid_q || m_axis.tready;
    assign s_ready_c  = (state_q == ST_RUN) && out_free_c;
    assign accept_c   = s_axis.tvalid && s_ready_c;
    assign icrc_bytes = crc_c;

    roce_icrc_calc u_calc (
        .core_clk     (core_clk),
        .core_aresetn (core_aresetn),
        .beat_en      (accept_c),
        .beat_last    (s_axis.tlast),
        .beat_data    (s_axis.tdata),
        .beat_keep    (s_axis.tkeep),
        .crc_c        (crc_c)
    );

    // Last-beat assembly: ICRC bytes follow the final valid byte, overflow goes to the spill beat
    always_comb begin
        nbytes_c  = '0;
        lane_ofs  = '0;
        spill_ofs = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            nbytes_c = nbytes_c + 7'(s_axis.tkeep[i]);
        end
        spill_c = nbytes_c > 7'(SPILL_AT);

        tail_beat_c.tdata = s_axis.tdata;
        tail_beat_c.tkeep = s_axis.tkeep;
        tail_beat_c.tlast = !spill_c;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_ofs = 7'(i) - nbytes_c;
            if ((7'(i) >= nbytes_c) && (lane_ofs < 7'(ICRC_BYTES))) begin
                tail_beat_c.tdata[8*i +: 8] = icrc_bytes[lane_ofs[1:0]];
                tail_beat_c.tkeep[i]        = 1'b1;
            end
        end

        spill_beat_c       = '0;
        spill_beat_c.tlast = 1'b1;
        for (int unsigned j = 0; j < ICRC_BYTES; j++) begin
            spill_ofs = 7'(j) + 7'(LANES) - nbytes_c;
            if ((7'(j) + 7'(SPILL_AT)) < nbytes_c) begin
                spill_beat_c.tdata[8*j +: 8] = icrc_bytes[spill_ofs[1:0]];
                spill_beat_c.tkeep[j]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        spill_d     = spill_q;

        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept_c) begin
                    out_valid_d = 1'b1;
                    if (s_axis.tlast) begin
                        out_d = tail_beat_c;
                        if (spill_c) begin
                            spill_d = spill_beat_c;
                            state_d = ST_SPILL;
                        end
                    end else begin
                        out_d.tdata = s_axis.tdata;
                        out_d.tkeep = s_axis.tkeep;
                        out_d.tlast = 1'b0;
                    end
                end
            end
            ST_SPILL: begin
                if (out_free_c) begin
                    out_d       = spill_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            state_q     <= ST_RESET;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            spill_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            spill_q     <= spill_d;
        end
    end

    assign s_axis.tready = s_ready_c;
    assign m_axis.tdata  = out_q.tdata;
    assign m_axis.tkeep  = out_q.tkeep;
    assign m_axis.tlast  = out_q.tlast;
    assign m_axis.tvalid = out_valid_q;

endmodule

// File: tb/tb_roce_icrc_append.sv
// Directed bench for roce_icrc_append: builds frames, checks forwarded bytes and ICRC against a software CRC-32.
module tb_roce_icrc_append;
    import roce_icrc_pkg::*;

    logic core_clk     = 1'b0;
    logic core_aresetn = 1'b0;

    roce_icrc_append_if s_if ();
    roce_icrc_append_if m_if ();

    roce_icrc_append #(.C_AXIS_DATA_WIDTH(512)) dut (
        .core_clk     (core_clk),
        .core_aresetn (core_aresetn),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master)
    );

    always #5 core_clk = ~core_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tready_mode = 0;
    int hold_err    = 0;

    logic [7:0]   fb [4][512];
    int           fl [4];
    logic [511:0] cap_d[$];
    logic [63:0]  cap_k[$];
    logic         cap_l[$];
    int           acc_cyc[$];
    logic [511:0] pf_d [16];
    logic [63:0]  pf_k [16];
    logic         pf_l [16];

    always @(posedge core_clk) cyc = cyc + 1;

    always @(negedge core_clk) begin
        if (tready_mode == 1) m_if.tready = ~m_if.tready;
        else m_if.tready = 1'b1;
    end

    // Output capture plus stability check of stalled beats
    logic [511:0] mon_pd;
    logic [63:0]  mon_pk;
    logic         mon_pl;
    bit           mon_stall = 0;
    always @(negedge core_clk) begin
        #2;
        if (core_aresetn !== 1'b1) begin
            mon_stall = 0;
        end else begin
            if (mon_stall && !(m_if.tvalid === 1'b1 && m_if.tdata === mon_pd &&
                               m_if.tkeep === mon_pk && m_if.tlast === mon_pl))
                hold_err++;
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                cap_d.push_back(m_if.tdata);
                cap_k.push_back(m_if.tkeep);
                cap_l.push_back(m_if.tlast);
            end
            mon_stall = (m_if.tvalid === 1'b1 && m_if.tready === 1'b0);
            mon_pd = m_if.tdata;
            mon_pk = m_if.tkeep;
            mon_pl = m_if.tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc32_sw(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] model_icrc(input int fi);
        logic [7:0] q[$];
        for (int i = 0; i < 8; i++) q.push_back(8'hFF);
        for (int i = 14; i < fl[fi]; i++)
            q.push_back((i inside {15, 22, 24, 25, 40, 41, 46}) ? 8'hFF : fb[fi][i]);
        return crc32_sw(q);
    endfunction

    task automatic make_frame(input int fi, input int len, input int seed);
        fl[fi] = len;
        for (int i = 0; i < len; i++) fb[fi][i] = 8'(i * 7 + seed * 29 + 3);
        fb[fi][12] = 8'h08;
        fb[fi][13] = 8'h00;
        fb[fi][14] = 8'h45;
    endtask

    task automatic copy_frame(input int dst, input int src);
        fl[dst] = fl[src];
        for (int i = 0; i < fl[src]; i++) fb[dst][i] = fb[src][i];
    endtask

    task automatic clear_capture();
        cap_d.delete();
        cap_k.delete();
        cap_l.delete();
    endtask

    task automatic apply_beat(input int fi, input int b);
        logic [511:0] d;
        logic [63:0]  k;
        int idx;
        d = '0;
        k = '0;
        for (int l = 0; l < 64; l++) begin
            idx = b * 64 + l;
            if (idx < fl[fi]) begin
                d[8*l +: 8] = fb[fi][idx];
                k[l] = 1'b1;
            end
        end
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = ((b + 1) * 64 >= fl[fi]);
        s_if.tvalid = 1'b1;
    endtask

    task automatic send_frames(input int first, input int nf);
        bit chk_spill;
        int t, nb, rem;
        chk_spill = 0;
        @(posedge core_clk); #1;
        for (int f = first; f < first + nf; f++) begin
            nb = (fl[f] + 63) / 64;
            for (int b = 0; b < nb; b++) begin
                apply_beat(f, b);
                t = 0;
                forever begin
                    @(negedge core_clk); #2;
                    if (chk_spill) begin
                        checks++;
                        if (s_if.tready !== 1'b0) begin
                            errors++;
                            $display("FAIL spill_ready: s_axis_tready=%b required 0", s_if.tready);
                        end
                        chk_spill = 0;
                    end
                    if (s_if.tready === 1'b1) break;
                    t++;
                    if (t > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL accept_timeout: frame %0d beat %0d not accepted", f, b);
                        s_if.tvalid = 1'b0;
                        return;
                    end
                end
                @(posedge core_clk); #1;
                acc_cyc.push_back(cyc);
                rem = fl[f] % 64;
                if (b == nb - 1 && (rem == 0 || rem > 60)) chk_spill = 1;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (chk_spill) begin
            @(negedge core_clk); #2;
            checks++;
            if (s_if.tready !== 1'b0) begin
                errors++;
                $display("FAIL spill_ready: s_axis_tready=%b required 0", s_if.tready);
            end
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int cnt;
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge core_clk); #3;
            cnt = 0;
            foreach (cap_l[i]) if (cap_l[i] === 1'b1) cnt++;
            if (cnt >= n) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic pop_frame(input int fi, output int nb, output logic [31:0] icrc,
                             output bit keep_ok, output bit pay_ok);
        logic [7:0]   q[$];
        logic [511:0] d;
        logic [63:0]  k;
        logic         lst;
        int n;
        nb = 0; keep_ok = 1; pay_ok = 1; icrc = '0;
        while (cap_d.size() > 0 && nb < 16) begin
            d = cap_d.pop_front();
            k = cap_k.pop_front();
            lst = cap_l.pop_front();
            pf_d[nb] = d; pf_k[nb] = k; pf_l[nb] = lst;
            nb++;
            for (int i = 0; i < 64; i++) if (k[i]) q.push_back(d[8*i +: 8]);
            if (!lst && k !== {64{1'b1}}) keep_ok = 0;
            if (lst) begin
                if ((k & (k + 64'd1)) != 64'd0) keep_ok = 0;
                break;
            end
        end
        n = q.size();
        if (n >= 4) icrc = {q[n-1], q[n-2], q[n-3], q[n-4]};
        if (n != fl[fi] + 4) pay_ok = 0;
        else for (int i = 0; i < fl[fi]; i++) if (q[i] !== fb[fi][i]) pay_ok = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge core_clk);
        #2;
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b expected 0", s_if.tready); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 0", m_if.tvalid); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %b expected 0", m_if.tlast); end
        checks++; if (m_if.tkeep !== 64'd0) begin errors++; $display("FAIL rst_m_tkeep: got %h expected 0", m_if.tkeep); end
        checks++; if (m_if.tdata !== 512'd0) begin errors++; $display("FAIL rst_m_tdata: got nonzero expected 0"); end
        @(negedge core_clk);
        core_aresetn = 1'b1;
        repeat (2) @(negedge core_clk);
    endtask

    task automatic test_model_kat();
        logic [7:0] q[$];
        logic [31:0] c;
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        c = crc32_sw(q);
        checks++; if (c !== 32'hCBF4_3926) begin errors++; $display("FAIL model_kat: got %h expected cbf43926", c); end
    endtask

    task automatic test_cm_frame();
        bit ok, kok, pok, full;
        int nb;
        logic [31:0] icrc, exp;
        clear_capture();
        make_frame(0, 318, 1);
        exp = model_icrc(0);
        send_frames(0, 1);
        wait_frames(1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cm_timeout: got no tlast expected 1 frame"); end
        pop_frame(0, nb, icrc, kok, pok);
        full = 1;
        for (int i = 0; i < 5; i++) if (pf_k[i] !== {64{1'b1}}) full = 0;
        checks++; if (nb !== 6) begin errors++; $display("FAIL cm_beats: got %0d expected 6", nb); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL cm_keep_full: got partial keep expected all-ones beats 0-4"); end
        checks++; if (pf_l[4] !== 1'b0) begin errors++; $display("FAIL cm_beat4_last: got %b expected 0", pf_l[4]); end
        checks++; if (pf_d[4][511:496] !== exp[15:0]) begin errors++; $display("FAIL cm_beat4_icrc: got %h expected %h", pf_d[4][511:496], exp[15:0]); end
        checks++; if (pf_k[5] !== 64'h3) begin errors++; $display("FAIL cm_spill_keep: got %h expected 3", pf_k[5]); end
        checks++; if (pf_l[5] !== 1'b1) begin errors++; $display("FAIL cm_spill_last: got %b expected 1", pf_l[5]); end
        checks++; if (pf_d[5][15:0] !== exp[31:16]) begin errors++; $display("FAIL cm_spill_icrc: got %h expected %h", pf_d[5][15:0], exp[31:16]); end
        checks++; if (icrc !== exp) begin errors++; $display("FAIL cm_icrc: got %h expected %h", icrc, exp); end
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL cm_payload: got altered frame bytes expected original"); end
    endtask

    task automatic test_short_frame();
        bit ok, kok, pok;
        int nb;
        logic [31:0] icrc, exp0, exp1;
        clear_capture();
        acc_cyc.delete();
        make_frame(0, 60, 2);
        make_frame(1, 318, 3);
        exp0 = model_icrc(0);
        exp1 = model_icrc(1);
        send_frames(0, 2);
        wait_frames(2, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL short_timeout: got fewer frames expected 2"); end
        pop_frame(0, nb, icrc, kok, pok);
        checks++; if (nb !== 1) begin errors++; $display("FAIL short_beats: got %0d expected 1", nb); end
        checks++; if (pf_k[0] !== {64{1'b1}}) begin errors++; $display("FAIL short_keep: got %h expected all-ones", pf_k[0]); end
        checks++; if (pf_l[0] !== 1'b1) begin errors++; $display("FAIL short_last: got %b expected 1", pf_l[0]); end
        checks++; if (pf_d[0][511:480] !== exp0) begin errors++; $display("FAIL short_icrc: got %h expected %h", pf_d[0][511:480], exp0); end
        checks++; if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 1) begin errors++; $display("FAIL short_next_accept: got gap %0d expected 1", (acc_cyc.size() < 2) ? -1 : acc_cyc[1] - acc_cyc[0]); end
        pop_frame(1, nb, icrc, kok, pok);
        checks++; if (icrc !== exp1) begin errors++; $display("FAIL short_follow_icrc: got %h expected %h", icrc, exp1); end
    endtask

    task automatic test_invariance();
        bit ok, kok, pok0, pok1, pok2;
        int nb;
        logic [31:0] ic0, ic1, ic2, exp0, exp2;
        clear_capture();
        make_frame(0, 318, 4);
        copy_frame(1, 0);
        copy_frame(2, 0);
        foreach (fb[1][i]) if (i inside {15, 22, 24, 25, 40, 41, 46}) fb[1][i] = fb[1][i] ^ 8'h5A;
        fb[2][50] = fb[2][50] ^ 8'h01;
        exp0 = model_icrc(0);
        exp2 = model_icrc(2);
        send_frames(0, 3);
        wait_frames(3, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL inv_timeout: got fewer frames expected 3"); end
        pop_frame(0, nb, ic0, kok, pok0);
        pop_frame(1, nb, ic1, kok, pok1);
        pop_frame(2, nb, ic2, kok, pok2);
        checks++; if (ic0 !== exp0) begin errors++; $display("FAIL inv_icrc_base: got %h expected %h", ic0, exp0); end
        checks++; if (ic1 !== exp0) begin errors++; $display("FAIL inv_icrc_masked: got %h expected %h", ic1, exp0); end
        checks++; if (pok1 !== 1'b1) begin errors++; $display("FAIL inv_payload_masked: got altered bytes expected original"); end
        checks++; if (ic2 === ic0) begin errors++; $display("FAIL inv_icrc_b50: got %h expected value differing from %h", ic2, ic0); end
        checks++; if (ic2 !== exp2) begin errors++; $display("FAIL inv_icrc_b50_model: got %h expected %h", ic2, exp2); end
    endtask

    task automatic test_backpressure();
        bit ok, kok, pok;
        int nb;
        logic [31:0] icrc, exp;
        clear_capture();
        hold_err = 0;
        make_frame(0, 318, 5);
        exp = model_icrc(0);
        tready_mode = 1;
        send_frames(0, 1);
        wait_frames(1, ok);
        tready_mode = 0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got no tlast expected 1 frame"); end
        pop_frame(0, nb, icrc, kok, pok);
        checks++; if (nb !== 6) begin errors++; $display("FAIL bp_beats: got %0d expected 6", nb); end
        checks++; if (kok !== 1'b1) begin errors++; $display("FAIL bp_keep: got irregular keep expected full beats then contiguous tail"); end
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL bp_payload: got altered or lost bytes expected original"); end
        checks++; if (icrc !== exp) begin errors++; $display("FAIL bp_icrc: got %h expected %h", icrc, exp); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalled cycles expected 0", hold_err); end
    endtask

    task automatic test_reset_midframe();
        bit ok, kok, pok;
        int nb, t;
        logic [31:0] icrc, exp;
        clear_capture();
        make_frame(0, 318, 6);
        make_frame(1, 318, 7);
        exp = model_icrc(1);
        @(posedge core_clk); #1;
        for (int b = 0; b < 2; b++) begin
            apply_beat(0, b);
            t = 0;
            forever begin
                @(negedge core_clk); #2;
                if (s_if.tready === 1'b1 || t > 50) break;
                t++;
            end
            @(posedge core_clk); #1;
        end
        apply_beat(0, 2);
        @(negedge core_clk);
        core_aresetn = 1'b0;
        #2;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b expected 0", m_if.tvalid); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_tready: got %b expected 0", s_if.tready); end
        @(negedge core_clk);
        s_if.tvalid = 1'b0;
        core_aresetn = 1'b1;
        repeat (3) @(negedge core_clk);
        clear_capture();
        send_frames(1, 1);
        wait_frames(1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst_timeout: got no tlast expected 1 frame"); end
        pop_frame(1, nb, icrc, kok, pok);
        checks++; if (nb !== 6) begin errors++; $display("FAIL midrst_beats: got %0d expected 6", nb); end
        checks++; if (icrc !== exp) begin errors++; $display("FAIL midrst_icrc: got %h expected %h", icrc, exp); end
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL midrst_payload: got altered bytes expected original"); end
    endtask

    task automatic test_back_to_back();
        bit ok, kok, pok0, pok1;
        int nb, total;
        logic [31:0] ic0, ic1, exp0, exp1;
        clear_capture();
        make_frame(0, 318, 8);
        make_frame(1, 318, 9);
        exp0 = model_icrc(0);
        exp1 = model_icrc(1);
        send_frames(0, 2);
        wait_frames(2, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got fewer frames expected 2"); end
        total = cap_d.size();
        checks++; if (total !== 12) begin errors++; $display("FAIL b2b_beats: got %0d expected 12", total); end
        pop_frame(0, nb, ic0, kok, pok0);
        pop_frame(1, nb, ic1, kok, pok1);
        checks++; if (ic0 !== exp0) begin errors++; $display("FAIL b2b_icrc0: got %h expected %h", ic0, exp0); end
        checks++; if (ic1 !== exp1) begin errors++; $display("FAIL b2b_icrc1: got %h expected %h", ic1, exp1); end
        checks++; if (pok0 !== 1'b1 || pok1 !== 1'b1) begin errors++; $display("FAIL b2b_payload: got %b%b expected 11", pok0, pok1); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        test_reset();
        test_model_kat();
        test_cm_frame();
        test_short_frame();
        test_invariance();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/roce_icrc_append.md
Name: roce_icrc_append

Overview:
- AXI4-Stream inline stage that computes the RoCEv2 ICRC (invariant CRC32) of each IPv4/UDP/BTH Ethernet frame and appends it as 4 trailing bytes.
- Sits between a packet source (CM/MAD packet generator, RDMA TX path) and the MAC TX stream.
- Input frames carry no ICRC; their IP/UDP lengths already include the 4 ICRC bytes.
- The optional debug probe (ila_CM_crc, vendor ILA, DEBUG_ILA only) is out of scope for this block.

Parameters:
- C_AXIS_DATA_WIDTH, 512, stream data width in bits. Only 512 is supported, giving 64 byte lanes.

Ports:
- core_clk  in  1  clock
- core_aresetn  in  1  reset
- s_axis_tdata  in  512  input frame data; byte 0 (first on wire) in bits [7:0]
- s_axis_tkeep  in  64  byte enables; contiguous from lane 0
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last input beat
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  512  output frame data including ICRC
- m_axis_tkeep  out  64  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last output beat
- m_axis_tready  in  1  downstream ready

Behaviour:
- Reset: core_aresetn, asynchronous, active-low; clock core_clk. Reset clears m_axis_tvalid, m_axis_tlast, m_axis_tkeep and m_axis_tdata to 0 and clears the CRC state and spill flag.
- s_axis_tready is 0 during reset.
- A reset asserted mid-frame discards the frame; the output stream restarts clean.
- CRC definition:
  - CRC-32 (reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF).
  - CRC input sequence: 8 bytes of 0xFF (dummy LRH), then frame bytes 14..end. The Ethernet header is excluded.
- Invariant masking before CRC (byte offsets within the frame), each byte replaced by 0xFF:
  - 15 (IP TOS)
  - 22 (TTL)
  - 24 and 25 (IP checksum)
  - 40 and 41 (UDP checksum)
  - 46 (BTH resv8a)
- Transmitted data is never modified by the masking.
- Frame assumptions:
  - The first beat of a frame is always a full 64-byte beat, so all masked bytes are in beat 0.
  - Only IPv4 (ethertype 0x0800) frames are supported.
- ICRC append: the final CRC value C is appended as bytes C[7:0], C[15:8], C[23:16], C[31:24], immediately after the last valid input byte.
- Last input beat with n valid bytes:
  - n ≤ 60: one output beat with n+4 keep bits set and tlast=1.
  - n > 60: a full output beat (tlast=0), then a spill beat carrying the remaining n−60 ICRC bytes, keep = (1<<(n−60))−1, tlast=1.
- Pipeline:
  - One registered output stage with 1-cycle latency: an input beat accepted in cycle t is presented at m_axis in cycle t+1.
  - s_axis_tready = (output empty OR m_axis_tready) AND no spill beat pending.
  - Output holds tdata/tkeep/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
- CRC state is updated only on an accepted input beat (valid & ready). It is reinitialised after the tlast beat, so back-to-back frames need no idle cycle.
- Non-last beats pass through unchanged with their original tkeep.
- Throughput: 1 beat/cycle, plus one stall cycle only when a spill beat is inserted.

Decomposition:
- Package roce_icrc_pkg holds:
  - CRC polynomial, init and final-XOR constants
  - mask offset constants (15, 22, 24, 25, 40, 41, 46) and ETH_HDR_LEN = 14
  - the byte-wise CRC update function
- One natural sub-module, roce_icrc_calc: masked, keep-qualified 64-byte CRC accumulator with start/last controls.
- The top level handles the output register and spill.

Test Plan:
- 318-byte CM frame (beats of 64,64,64,64,62 bytes), m_axis_tready=1 → 6 output beats:
  - beats 0-4 keep all-ones; beat 4 bytes 62-63 = ICRC[7:0], ICRC[15:8]
  - beat 5 keep 0x3, tlast=1, bytes = ICRC[23:16], ICRC[31:24]
  - ICRC equals a software zlib-CRC32 model of the masked sequence
- 60-byte frame → single output beat, keep all-ones, tlast=1, bytes 60-63 = ICRC; first s_axis beat of the next frame accepted the following cycle.
- Invariance: two 318-byte frames differing only in TTL, TOS, IP checksum, UDP checksum and byte 46 → identical appended ICRC. Changing byte 50 → different ICRC.
- Backpressure: m_axis_tready toggling 1010… during a 318-byte frame → output data/keep stable while stalled, no beat lost or duplicated, s_axis_tready deasserted during spill.
- Reset: core_aresetn pulsed low during beat 2 of a frame → m_axis_tvalid=0 immediately; next full frame's ICRC matches the model.
- Back-to-back 318-byte frames with s_axis_tvalid held high → 12 output beats, each frame's ICRC independent and correct.
